// File: rtl/jtag_led_pkg.sv
// rtl/jtag_led_pkg.sv - shared types and constants for the JTAG LED pattern engine
package jtag_led_pkg;

    localparam int NUM_LEDS = 4;

    localparam int CMD_OP_HI  = 7;
    localparam int CMD_OP_LO  = 6;
    localparam int CMD_IDX_HI = 5;
    localparam int CMD_IDX_LO = 4;
    localparam int CMD_ARG_HI = 3;
    localparam int CMD_ARG_LO = 0;

    typedef enum logic [1:0] {
        OP_SET_DUTY = 2'b00,
        OP_BLINK    = 2'b01,
        OP_ALL_OFF  = 2'b10,
        OP_RSVD     = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_PWM   = 2'b01,
        MODE_BLINK = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

endpackage

// File: rtl/jtag_led_ctrl_if.sv
// rtl/jtag_led_ctrl_if.sv - command handshake and LED/status bundle
interface jtag_led_ctrl_if;
    import jtag_led_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [7:0]          cmd_data;
    logic [NUM_LEDS-1:0] led;
    logic [7:0]          status;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  led,
        input  status
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output led,
        output status
    );
endinterface

// File: rtl/jtag_led_channel.sv
// rtl/jtag_led_channel.sv - one LED channel: mode, duty, blink period/count/phase, registered on-state
module jtag_led_channel
    import jtag_led_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pwm_cnt,
    input  logic       blink_tick,
    input  logic       wr_en,
    input  mode_e      wr_mode,
    input  logic [3:0] wr_arg,
    output logic       lit,
    output logic       is_blink
);
    mode_e      mode_q, mode_d;
    logic [3:0] duty_q, duty_d;
    logic [3:0] period_q, period_d;
    logic [3:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       lit_q, lit_d;

    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        lit_d    = 1'b0;

        // A write always wins over a coincident blink tick
        if (wr_en) begin
            mode_d  = wr_mode;
            cnt_d   = 4'd0;
            phase_d = 1'b0;
            if (wr_mode == MODE_PWM)   duty_d   = wr_arg;
            if (wr_mode == MODE_BLINK) period_d = wr_arg;
        end else if (blink_tick && (mode_q == MODE_BLINK)) begin
            if (cnt_q == period_q) begin
                cnt_d   = 4'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        case (mode_q)
            MODE_PWM:   lit_d = (duty_q == 4'hF) || (pwm_cnt < duty_q);
            MODE_BLINK: lit_d = phase_q;
            default:    lit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            duty_q   <= 4'd0;
            period_q <= 4'd0;
            cnt_q    <= 4'd0;
            phase_q  <= 1'b0;
            lit_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            lit_q    <= lit_d;
        end
    end

    assign lit      = lit_q;
    assign is_blink = (mode_q == MODE_BLINK);
endmodule

// File: rtl/jtag_led_ctrl.sv
// rtl/jtag_led_ctrl.sv - command FSM, prescalers and decode driving four LED channels
module jtag_led_ctrl
    import jtag_led_pkg::*;
#(
    parameter int PWM_DIV   = 64,
    parameter int BLINK_DIV = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    jtag_led_ctrl_if.slave  bus
);
    localparam int PW = (PWM_DIV   > 1) ? $clog2(PWM_DIV)   : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [PW-1:0]       pwm_presc_q, pwm_presc_d;
    logic [3:0]          pwm_cnt_q, pwm_cnt_d;
    logic [BW-1:0]       blink_presc_q, blink_presc_d;
    logic                pwm_step;
    logic                blink_tick;
    logic                accept;
    opcode_e             cmd_op;
    logic [1:0]          cmd_idx;
    logic [3:0]          cmd_arg;
    logic [NUM_LEDS-1:0] wr_en;
    mode_e               wr_mode;
    logic [NUM_LEDS-1:0] lit;
    logic [NUM_LEDS-1:0] is_blink;

    assign cmd_op  = opcode_e'(cmd_q[CMD_OP_HI:CMD_OP_LO]);
    assign cmd_idx = cmd_q[CMD_IDX_HI:CMD_IDX_LO];
    assign cmd_arg = cmd_q[CMD_ARG_HI:CMD_ARG_LO];
    assign accept  = bus.cmd_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wr_en   = '0;
        wr_mode = MODE_OFF;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = bus.cmd_data;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                case (cmd_op)
                    OP_SET_DUTY: begin
                        wr_en[cmd_idx] = 1'b1;
                        wr_mode        = MODE_PWM;
                    end
                    OP_BLINK: begin
                        wr_en[cmd_idx] = 1'b1;
                        wr_mode        = MODE_BLINK;
                    end
                    OP_ALL_OFF: wr_en = '1;
                    OP_RSVD:    wr_en = '0;
                endcase
            end
        endcase

        // Registered so ready stays low through reset and rises on the first released edge
        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        pwm_step      = (pwm_presc_q == PW'(PWM_DIV - 1));
        pwm_presc_d   = pwm_step ? '0 : pwm_presc_q + PW'(1);
        pwm_cnt_d     = pwm_step ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
        blink_tick    = (blink_presc_q == BW'(BLINK_DIV - 1));
        blink_presc_d = blink_tick ? '0 : blink_presc_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            cmd_q         <= 8'h00;
            pwm_presc_q   <= '0;
            pwm_cnt_q     <= 4'd0;
            blink_presc_q <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            cmd_q         <= cmd_d;
            pwm_presc_q   <= pwm_presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_presc_q <= blink_presc_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        jtag_led_channel u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .pwm_cnt    (pwm_cnt_q),
            .blink_tick (blink_tick),
            .wr_en      (wr_en[i]),
            .wr_mode    (wr_mode),
            .wr_arg     (cmd_arg),
            .lit        (lit[i]),
            .is_blink   (is_blink[i])
        );
    end

    assign bus.cmd_ready = ready_q;
    assign bus.led       = ~lit;
    assign bus.status    = {is_blink, lit};
endmodule

// File: doc/jtag_led_ctrl.md
# jtag_led_ctrl

LED pattern engine that sits directly downstream of the JTAG user-register capture path. It accepts 8-bit command words, already moved into the fabric clock domain, through a valid/ready handshake, and drives four active-low LEDs in off, PWM-dimmed or blinking modes. It also returns an 8-bit status word that the JTAG capture path can shift back out on TDO.

## Interface
- `PWM_DIV`, default 64: clocks per PWM counter step; must be ≥ 1.
- `BLINK_DIV`, default 1_000_000: clocks per blink tick; must be ≥ 1.
- `clk`, input, 1: fabric clock; all logic is on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `cmd_valid`, input, 1: `cmd_data` holds a command.
- `cmd_ready`, output, 1: block can accept a command this cycle.
- `cmd_data`, input, 8: bits [7:6] opcode, [5:4] LED index, [3:0] argument.
- `led`, output, 4: LED drive, active-low (0 = lit).
- `status`, output, 8: {blink_mask[3:0], lit[3:0]}.

## Operation
- Reset, active-low and synchronous on `clk`:
  - every channel goes to mode OFF, duty 0, period 0;
  - `led` = 4'b1111, `status` = 8'h00, `cmd_ready` = 0;
  - all prescalers and counters clear.
- FSM states are IDLE and APPLY.
  - In IDLE, `cmd_ready` = 1. On `cmd_valid` && `cmd_ready`, the block registers `cmd_data` and moves to APPLY.
  - In APPLY, `cmd_ready` = 0. The command is written to the addressed channel and the FSM returns to IDLE.
  - The maximum accept rate is therefore one command every 2 cycles.
- Opcodes:
  - 2'b00 SET_DUTY: channel[idx] mode = PWM, duty = arg. Duty 0 is dark and duty 15 is full on; otherwise the LED is lit while `pwm_cnt < duty`.
  - 2'b01 BLINK: channel[idx] mode = BLINK, period = arg. The channel's phase toggles after every (arg+1) blink ticks and the LED is lit during phase 1. Phase and count reset to 0 when the command is applied.
  - 2'b10 ALL_OFF: all four channels go to OFF; `idx` and `arg` are ignored.
  - 2'b11 RESERVED: the command is accepted and then ignored, with no state change.
- Counters and outputs:
  - `pwm_cnt` is 4 bits and free-running. It advances when the PWM prescaler reaches PWM_DIV−1, then the prescaler returns to 0. `pwm_cnt` wraps 15→0.
  - The blink tick is a one-cycle pulse when the blink prescaler reaches BLINK_DIV−1. It is shared by all channels.
  - `lit[i]` is the registered on-state of channel i. `led[i]` = ~`lit[i]`. `blink_mask[i]` = 1 when channel i is in BLINK mode.
- Boundary behaviour:
  - A new command to a channel overrides its previous mode on the APPLY cycle. Prescalers and `pwm_cnt` are not disturbed.
  - A blink tick in the same cycle as a BLINK apply to the same channel: the apply wins (phase 0, count 0) and the tick is discarded for that channel.
  - `cmd_valid` dropping while `cmd_ready` = 0 is legal and loses nothing, because the command was already registered.
  - Reset asserted during APPLY drops the pending command.

## Timing
- The command is accepted at edge N and applied to the channel registers at edge N+1. `lit`/`led` reflect the new mode at edge N+2.
- `status` follows `lit` and mode with no extra delay.
- `cmd_ready` first rises on the first edge with `rst_n` = 1.
- PWM frame length is 16·PWM_DIV clocks.
- The BLINK phase toggles every (arg+1)·BLINK_DIV clocks.

## Structure
- `jtag_led_pkg` holds:
  - the opcode enum (OP_SET_DUTY, OP_BLINK, OP_ALL_OFF, OP_RSVD);
  - the mode enum (MODE_OFF, MODE_PWM, MODE_BLINK);
  - the command field bit positions;
  - NUM_LEDS = 4.
- Sub-module `jtag_led_channel` has four instances, one per LED. It holds mode, duty, period, blink count and phase. Its inputs are `pwm_cnt`, the blink tick and a write strobe with fields; it outputs `lit`.
- The top level holds the FSM, the prescalers, `pwm_cnt` and the command decode.

## Test plan
The bench runs with PWM_DIV = 1 and BLINK_DIV = 4.
- **Reset:** hold `rst_n` = 0 for 3 cycles while `cmd_valid` = 1. Required: `led` = 4'b1111, `status` = 8'h00, `cmd_ready` = 0 throughout. `cmd_ready` = 1 after the first edge with `rst_n` = 1.
- **Full on:** send SET_DUTY idx 2, arg 15 (8'h2F). Required: from edge N+2 onward, `led` = 4'b1011 and `status` = 8'h04 constantly over 32 cycles.
- **PWM:** send SET_DUTY idx 0, arg 4 (8'h04). Required: `led[0]` low for exactly 4 of every 16 cycles, aligned to `pwm_cnt` = 0..3.
- **Blink:** send BLINK idx 1, arg 1 (8'h51). Required: `status[5]` = 1 and `led[1]` toggles every 8 cycles.
- **Handshake:** hold `cmd_valid` = 1 with 4 different commands. Required: each command accepted on alternate cycles and `cmd_ready` reads 1,0,1,0. The last command wins.
- **Override and reserved:** run ALL_OFF (8'h80) while 3 channels are active, then send RESERVED (8'hC5). Required: `led` = 4'b1111 and `status` = 8'h00 after ALL_OFF; no change after RESERVED.
